// File: rtl/debug_cmd_initiator.sv
// debug_cmd_initiator
// Command-issuing end of the single-step debug UART link. Sends one command
// character through an external UART transmitter, then collects the reply
// through an external UART receiver: a 4-byte acknowledge that is checked
// against the expected text, or a 32-byte status frame that is stored in a
// small readable buffer.
module debug_cmd_initiator #(
  // Cycles allowed between consecutive expected reply bytes.
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  input  logic [2:0] cmd_i,
  input  logic [7:0] raw_byte_i,
  output logic       cmd_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] result_o,
  output logic       tx_en_o,
  output logic [7:0] tx_byte_o,
  input  logic       tx_complete_i,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_complete_i,
  input  logic [4:0] frame_rd_addr_i,
  output logic [7:0] frame_rd_data_o,
  output logic       frame_valid_o
);

  // Counter width large enough to hold TIMEOUT_CYCLES itself.
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);

  localparam logic [4:0] LAST_ACK_IDX    = 5'd3;
  localparam logic [4:0] LAST_STATUS_IDX = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_SENDING,
    ST_RECV,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CMD_CPU_RESET  = 3'd0,
    CMD_CLK_RISE   = 3'd1,
    CMD_CLK_FALL   = 3'd2,
    CMD_CLK_TOGGLE = 3'd3,
    CMD_RST_TOGGLE = 3'd4,
    CMD_STATUS     = 3'd5,
    CMD_RAW        = 3'd6,
    CMD_ILLEGAL    = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    RES_OK       = 2'b00,
    RES_MISMATCH = 2'b01,
    RES_TIMEOUT  = 2'b10,
    RES_ILLEGAL  = 2'b11
  } result_e;

  // Character put on the wire for each command.
  function automatic logic [7:0] cmd_char(input cmd_e c, input logic [7:0] raw);
    logic [7:0] b;
    b = 8'h00;
    case (c)
      CMD_CPU_RESET:  b = 8'h72; // 'r'
      CMD_CLK_RISE:   b = 8'h7A; // 'z'
      CMD_CLK_FALL:   b = 8'h78; // 'x'
      CMD_CLK_TOGGLE: b = 8'h63; // 'c'
      CMD_RST_TOGGLE: b = 8'h65; // 'e'
      CMD_STATUS:     b = 8'h73; // 's'
      default:        b = raw;
    endcase
    return b;
  endfunction

  // Expected acknowledge byte idx for an acknowledged command.
  function automatic logic [7:0] ack_byte(input cmd_e c, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: begin
        case (c)
          CMD_CPU_RESET, CMD_RST_TOGGLE:             b = 8'h52; // 'R'
          CMD_CLK_RISE, CMD_CLK_FALL, CMD_CLK_TOGGLE: b = 8'h43; // 'C'
          default:                                    b = 8'h4F; // 'O'
        endcase
      end
      2'd1: begin
        case (c)
          CMD_CPU_RESET:  b = 8'h73; // 's'
          CMD_CLK_RISE:   b = 8'h72; // 'r'
          CMD_CLK_FALL:   b = 8'h66; // 'f'
          CMD_CLK_TOGGLE: b = 8'h74; // 't'
          CMD_RST_TOGGLE: b = 8'h61; // 'a'
          default:        b = 8'h6B; // 'k'
        endcase
      end
      2'd2:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [4:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          err_q, err_d;
  result_e       result_q, result_d;
  logic          frame_valid_q, frame_valid_d;

  logic          frame_we;
  logic [7:0]    frame_mem [32];

  logic          is_status;
  logic [4:0]    last_idx;
  logic          rx_match;

  assign is_status = (cmd_q == CMD_STATUS);
  assign last_idx  = is_status ? LAST_STATUS_IDX : LAST_ACK_IDX;
  assign rx_match  = (rx_byte_i == ack_byte(cmd_q, byte_cnt_q[1:0]));

  // State and datapath registers; everything except the frame buffer resets.
  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_i) begin
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_CPU_RESET;
      tx_byte_q     <= 8'h00;
      byte_cnt_q    <= 5'd0;
      timeout_q     <= '0;
      err_q         <= 1'b0;
      result_q      <= RES_OK;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      tx_byte_q     <= tx_byte_d;
      byte_cnt_q    <= byte_cnt_d;
      timeout_q     <= timeout_d;
      err_q         <= err_d;
      result_q      <= result_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Next-state logic: command accept, transmit handshake, reply collection.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    cmd_d         = cmd_q;
    tx_byte_d     = tx_byte_q;
    byte_cnt_d    = byte_cnt_q;
    timeout_d     = timeout_q;
    err_d         = err_q;
    result_d      = result_q;
    frame_valid_d = frame_valid_q;
    frame_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d = cmd_e'(cmd_i);
          if (cmd_e'(cmd_i) == CMD_ILLEGAL) begin
            // Nothing goes on the wire; report straight away.
            result_d = RES_ILLEGAL;
            state_d  = ST_DONE;
          end else begin
            tx_byte_d = cmd_char(cmd_e'(cmd_i), raw_byte_i);
            if (cmd_e'(cmd_i) == CMD_STATUS) begin
              frame_valid_d = 1'b0;
            end
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        // tx_en_o is low for exactly this one cycle.
        state_d = ST_SENDING;
      end

      ST_SENDING: begin
        if (tx_complete_i) begin
          byte_cnt_d = 5'd0;
          timeout_d  = TIMEOUT_LOAD;
          err_d      = 1'b0;
          state_d    = ST_RECV;
        end
      end

      ST_RECV: begin
        if (rx_complete_i) begin
          // A byte arriving on the expiry cycle still counts.
          timeout_d = TIMEOUT_LOAD;
          if (is_status) begin
            frame_we = 1'b1;
          end else if (!rx_match) begin
            err_d = 1'b1;
          end
          if (byte_cnt_q == last_idx) begin
            state_d = ST_DONE;
            if (is_status) begin
              frame_valid_d = 1'b1;
              result_d      = RES_OK;
            end else begin
              result_d = (err_q || !rx_match) ? RES_MISMATCH : RES_OK;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end else if (timeout_q <= TW'(1)) begin
          // The counter reaches zero on this decrement: give up waiting.
          timeout_d = '0;
          result_d  = RES_TIMEOUT;
          state_d   = ST_DONE;
        end else begin
          timeout_d = timeout_q - TW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status frame storage, written one reply byte at a time.
  always_ff @(posedge clk_i) begin
    // NOTE: the buffer is deliberately left out of reset; it is plain storage
    // qualified by frame_valid_o, and resetting it would block RAM inference.
    if (frame_we) begin
      frame_mem[byte_cnt_q] <= rx_byte_i;
    end
  end

  assign frame_rd_data_o = frame_mem[frame_rd_addr_i];
  assign frame_valid_o   = frame_valid_q;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign tx_en_o     = (state_q != ST_SEND);
  assign tx_byte_o   = tx_byte_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_debug_cmd_initiator.sv
// Self-checking bench for debug_cmd_initiator: directed vector table,
// hand-written corner sequences, then randomized commands checked against a
// protocol-level reference model.
module tb_debug_cmd_initiator;

  localparam int TO = 50;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       cmd_valid_i;
  logic [2:0] cmd_i;
  logic [7:0] raw_byte_i;
  logic       cmd_ready_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] result_o;
  logic       tx_en_o;
  logic [7:0] tx_byte_o;
  logic       tx_complete_i;
  logic [7:0] rx_byte_i;
  logic       rx_complete_i;
  logic [4:0] frame_rd_addr_i;
  logic [7:0] frame_rd_data_o;
  logic       frame_valid_o;

  debug_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_i           (cmd_i),
    .raw_byte_i      (raw_byte_i),
    .cmd_ready_o     (cmd_ready_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .tx_en_o         (tx_en_o),
    .tx_byte_o       (tx_byte_o),
    .tx_complete_i   (tx_complete_i),
    .rx_byte_i       (rx_byte_i),
    .rx_complete_i   (rx_complete_i),
    .frame_rd_addr_i (frame_rd_addr_i),
    .frame_rd_data_o (frame_rd_data_o),
    .frame_valid_o   (frame_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int tx_pulses = 0;

  // Count cycles with the transmitter start strobe asserted.
  always @(negedge clk_i) if (!tx_en_o) tx_pulses++;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not reach its end in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_frame [32];
  bit         exp_known [32];
  bit         exp_valid;
  logic [7:0] reply_q [$];
  int         gap_q [$];

  string cmd_chars = "rzxces";
  string ack_pairs = "RsCrCfCtRaOk";

  function automatic logic [7:0] exp_tx(input int cmd, input logic [7:0] raw);
    if (cmd == 6) return raw;
    if (cmd < 6) return cmd_chars[cmd];
    return 8'h00;
  endfunction

  function automatic logic [7:0] ack_ref(input int cmd, input int idx);
    int k;
    k = (cmd == 6) ? 5 : cmd;
    if (idx == 2) return 8'h0D;
    if (idx == 3) return 8'h0A;
    return ack_pairs[2 * k + idx];
  endfunction

  function automatic logic [1:0] predict(input int cmd);
    int need;
    if (cmd == 7) return 2'd3;
    need = (cmd == 5) ? 32 : 4;
    if (reply_q.size() < need) return 2'd2;
    if (cmd == 5) return 2'd0;
    for (int i = 0; i < 4; i++) if (reply_q[i] != ack_ref(cmd, i)) return 2'd1;
    return 2'd0;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic check_frame(input string name);
    for (int i = 0; i < 32; i++) begin
      if (exp_known[i]) begin
        frame_rd_addr_i = 5'(i);
        #1;
        check($sformatf("%s:frame[%0d]", name, i), 32'(frame_rd_data_o), 32'(exp_frame[i]));
      end
    end
    check({name, ":frame_valid"}, 32'(frame_valid_o), 32'(exp_valid));
    tick();
  endtask

  // Issue one command, play the UART side, and check the outcome.
  task automatic run_cmd(input string name, input int cmd, input logic [7:0] raw,
                         input logic [7:0] want_tx, input logic [1:0] want_res,
                         input bit poke, input bit stray);
    int k;
    int n0;
    bit stray_left;
    n0 = tx_pulses;
    stray_left = stray;
    k = 0;
    while (!cmd_ready_o && k < 200) begin tick(); k++; end
    check({name, ":ready"}, 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_i       = 3'(cmd);
    raw_byte_i  = raw;
    tick();
    cmd_valid_i = 1'b0;
    cmd_i       = 3'($urandom);
    raw_byte_i  = 8'($urandom);
    if (cmd == 5) exp_valid = 1'b0;
    if (cmd == 7) begin
      check({name, ":done_next"}, 32'(done_o), 32'd1);
      check({name, ":result"}, 32'(result_o), 32'(want_res));
      check({name, ":no_tx_en"}, 32'(tx_en_o), 32'd1);
      tick();
      check({name, ":ready_after"}, 32'(cmd_ready_o), 32'd1);
      check({name, ":tx_count"}, 32'(tx_pulses - n0), 32'd0);
    end else begin
      check({name, ":tx_en_low"}, 32'(tx_en_o), 32'd0);
      check({name, ":tx_byte"}, 32'(tx_byte_o), 32'(want_tx));
      check({name, ":busy"}, 32'(busy_o), 32'd1);
      if (poke) begin cmd_valid_i = 1'b1; cmd_i = 3'd1; end
      repeat (1 + $urandom_range(0, 3)) begin
        tick();
        if (stray_left) begin
          rx_byte_i = 8'hEE; rx_complete_i = 1'b1; tick(); rx_complete_i = 1'b0;
          stray_left = 1'b0;
        end
      end
      cmd_valid_i = 1'b0;
      check({name, ":tx_en_high"}, 32'(tx_en_o), 32'd1);
      check({name, ":tx_byte_hold"}, 32'(tx_byte_o), 32'(want_tx));
      tx_complete_i = 1'b1; tick(); tx_complete_i = 1'b0;
      for (int i = 0; i < reply_q.size(); i++) begin
        repeat (gap_q[i]) tick();
        rx_byte_i = reply_q[i]; rx_complete_i = 1'b1; tick(); rx_complete_i = 1'b0;
        rx_byte_i = 8'($urandom);
        if (cmd == 5 && i < 32) begin exp_frame[i] = reply_q[i]; exp_known[i] = 1'b1; end
      end
      if (cmd == 5 && reply_q.size() >= 32) exp_valid = 1'b1;
      k = 1;
      while (!done_o && k < TO + 20) begin tick(); k++; end
      check({name, ":done_latency"}, 32'(k), (want_res == 2'd2) ? 32'(TO + 1) : 32'd1);
      check({name, ":result"}, 32'(result_o), 32'(want_res));
      tick();
      check({name, ":ready_after"}, 32'(cmd_ready_o), 32'd1);
      check({name, ":done_single"}, 32'(done_o), 32'd0);
      check({name, ":result_held"}, 32'(result_o), 32'(want_res));
      check({name, ":tx_count"}, 32'(tx_pulses - n0), 32'd1);
    end
    check({name, ":frame_valid"}, 32'(frame_valid_o), 32'(exp_valid));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          cmd;
    logic [7:0]  raw;
    int          nrep;
    logic [31:0] rep;   // first reply byte in bits [31:24]
    logic [7:0]  tx;
    logic [1:0]  res;
    bit          poke;
    bit          stray;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 8'h00, 4, 32'h43720D0A, 8'h7A, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{0, 8'h00, 4, 32'h52730D0D, 8'h72, 2'd1, 1'b0, 1'b0};
    tbl[2] = '{2, 8'h00, 4, 32'h43660D0A, 8'h78, 2'd0, 1'b1, 1'b0};
    tbl[3] = '{3, 8'h00, 4, 32'h43740D0A, 8'h63, 2'd0, 1'b0, 1'b1};
    tbl[4] = '{4, 8'h00, 4, 32'h52610D0A, 8'h65, 2'd0, 1'b0, 1'b0};
    tbl[5] = '{6, 8'h41, 4, 32'h4F6B0D0A, 8'h41, 2'd0, 1'b0, 1'b0};
    tbl[6] = '{4, 8'h00, 4, 32'h43610D0A, 8'h65, 2'd1, 1'b0, 1'b0};
    tbl[7] = '{2, 8'h00, 4, 32'h43660A0A, 8'h78, 2'd1, 1'b0, 1'b0};
    tbl[8] = '{7, 8'h00, 0, 32'h00000000, 8'h00, 2'd3, 1'b0, 1'b0};
    tbl[9] = '{3, 8'h00, 2, 32'h43740000, 8'h63, 2'd2, 1'b0, 1'b0};

    exp_valid       = 1'b0;
    for (int i = 0; i < 32; i++) exp_known[i] = 1'b0;
    reset_i         = 1'b0;
    cmd_valid_i     = 1'b0;
    cmd_i           = 3'd0;
    raw_byte_i      = 8'h00;
    tx_complete_i   = 1'b0;
    rx_byte_i       = 8'h00;
    rx_complete_i   = 1'b0;
    frame_rd_addr_i = 5'd0;

    // Reset values.
    repeat (3) tick();
    check("rst:ready",       32'(cmd_ready_o),   32'd1);
    check("rst:busy",        32'(busy_o),        32'd0);
    check("rst:done",        32'(done_o),        32'd0);
    check("rst:result",      32'(result_o),      32'd0);
    check("rst:tx_en",       32'(tx_en_o),       32'd1);
    check("rst:tx_byte",     32'(tx_byte_o),     32'd0);
    check("rst:frame_valid", 32'(frame_valid_o), 32'd0);
    reset_i = 1'b1;
    tick();

    // Stray received byte while idle is ignored.
    rx_byte_i = 8'h52; rx_complete_i = 1'b1; tick(); rx_complete_i = 1'b0;
    check("idle_rx:busy", 32'(busy_o), 32'd0);
    check("idle_rx:done", 32'(done_o), 32'd0);

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      reply_q.delete();
      gap_q.delete();
      for (int j = 0; j < tbl[v].nrep; j++) begin
        reply_q.push_back(tbl[v].rep[31 - 8 * j -: 8]);
        gap_q.push_back(int'($urandom_range(0, 4)));
      end
      run_cmd($sformatf("vec%0d", v), tbl[v].cmd, tbl[v].raw, tbl[v].tx, tbl[v].res,
              tbl[v].poke, tbl[v].stray);
    end

    // Status frame 0x00..0x1F straight after the timeout.
    reply_q.delete();
    gap_q.delete();
    for (int j = 0; j < 32; j++) begin
      reply_q.push_back(8'(j));
      gap_q.push_back(int'($urandom_range(0, 3)));
    end
    run_cmd("status", 5, 8'h00, 8'h73, 2'd0, 1'b0, 1'b0);
    check_frame("status");

    // Each reply byte arrives on the last cycle before expiry: byte wins.
    reply_q.delete();
    gap_q.delete();
    for (int j = 0; j < 4; j++) begin
      reply_q.push_back(ack_ref(1, j));
      gap_q.push_back(TO - 1);
    end
    run_cmd("edge_gap", 1, 8'h00, 8'h7A, 2'd0, 1'b0, 1'b0);

    // Mismatch leaves result 01 and keeps the frame valid.
    reply_q.delete();
    gap_q.delete();
    reply_q.push_back(8'h52); reply_q.push_back(8'h00);
    reply_q.push_back(8'h0D); reply_q.push_back(8'h0A);
    for (int j = 0; j < 4; j++) gap_q.push_back(1);
    run_cmd("mism", 4, 8'h00, 8'h65, 2'd1, 1'b0, 1'b0);

    // Reset asserted while a status command is in the transmitter.
    cmd_valid_i = 1'b1; cmd_i = 3'd5; tick();
    cmd_valid_i = 1'b0;
    exp_valid   = 1'b0;
    check("mid_rst:tx_en_low", 32'(tx_en_o), 32'd0);
    tick();
    check("mid_rst:busy_before", 32'(busy_o), 32'd1);
    reset_i = 1'b0;
    #1;
    check("mid_rst:tx_en",       32'(tx_en_o),       32'd1);
    check("mid_rst:busy",        32'(busy_o),        32'd0);
    check("mid_rst:ready",       32'(cmd_ready_o),   32'd1);
    check("mid_rst:frame_valid", 32'(frame_valid_o), 32'd0);
    check("mid_rst:result",      32'(result_o),      32'd0);
    check("mid_rst:tx_byte",     32'(tx_byte_o),     32'd0);
    tick();
    reset_i = 1'b1;
    tick();
    // Completion of the abandoned transfer arrives late and is ignored.
    tx_complete_i = 1'b1; tick(); tx_complete_i = 1'b0;
    check("mid_rst:idle", 32'(busy_o), 32'd0);
    check_frame("retained");

    reply_q.delete();
    gap_q.delete();
    reply_q.push_back(8'h4F); reply_q.push_back(8'h6B);
    reply_q.push_back(8'h0D); reply_q.push_back(8'h0A);
    for (int j = 0; j < 4; j++) gap_q.push_back(2);
    run_cmd("raw_ok", 6, 8'h41, 8'h41, 2'd0, 1'b0, 1'b0);

    // Randomized commands against the reference model.
    for (int r = 0; r < 30; r++) begin
      int         cmd;
      int         need;
      int         n;
      logic [7:0] raw;
      logic [7:0] b;
      cmd = int'($urandom_range(0, 7));
      raw = 8'($urandom);
      reply_q.delete();
      gap_q.delete();
      if (cmd != 7) begin
        need = (cmd == 5) ? 32 : 4;
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, need - 1)) : need;
        for (int i = 0; i < n; i++) begin
          if (cmd == 5) begin
            b = 8'($urandom);
          end else begin
            b = ack_ref(cmd, i);
            if ($urandom_range(0, 3) == 0) b = b ^ (8'h01 << $urandom_range(0, 7));
          end
          reply_q.push_back(b);
          gap_q.push_back(($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3)));
        end
      end
      run_cmd($sformatf("rand%0d", r), cmd, raw, exp_tx(cmd, raw), predict(cmd),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      if (cmd == 5) check_frame($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
